// File: rtl/mealy_sym_packer.sv
// mealy_sym_packer
//   Takes the 2-bit symbol stream from the Mealy detector and packs it into
//   WORD_W-bit words. Completed words go into a DEPTH-entry first-word-fall-
//   through FIFO that has a valid/ready output port.
//
//   Optional build macro PACK_PARITY_EN adds the word_parity output. This is
//   the even parity of the head word. It is computed when the word is pushed
//   and stored in the FIFO entry alongside the word.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   sym_in        2-bit symbol; sampled when sym_valid is high
//   sym_valid     accept sym_in on this edge
//   flush         close the partial word (zero-padded) and push it
//   word_out      FIFO head word
//   word_partial  head word was closed by flush rather than by filling
//   word_parity   (PACK_PARITY_EN only) XOR of all bits of the head word
//   word_valid    FIFO non-empty
//   word_ready    consumer takes the head word when word_valid is high
//   fifo_level    number of stored words, 0..DEPTH
//   overflow      sticky; a completed word was dropped because the FIFO was full
//   overflow_clr  synchronous clear of overflow (a set in the same cycle wins)
//
// Packer FSM
//   state      | meaning
//   ST_EMPTY   | no symbols held for the current word (cnt_q == 0)
//   ST_FILLING | 0 < cnt_q < SPW symbols held for the current word

module mealy_sym_packer #(
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 sym_in,
  input  logic                       sym_valid,
  input  logic                       flush,
  output logic [WORD_W-1:0]          word_out,
  output logic                       word_partial,
`ifdef PACK_PARITY_EN
  output logic                       word_parity,
`endif
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int SPW   = WORD_W / 2;
  localparam int CNT_W = $clog2(SPW);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPW - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {ST_EMPTY, ST_FILLING} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  logic              last_sym;
  logic              push;
  logic              push_partial;
  logic [WORD_W-1:0] push_word;

  // ---------------- packer FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (push)
      state_d = ST_EMPTY;
    else if (sym_valid)
      state_d = ST_FILLING;
  end

  // The symbol accepted this cycle is merged into the word before any push.
  // Unfilled slots are already zero because sr_q is cleared on every push.
  always_comb begin
    push_word = sr_q;
    for (int k = 0; k < SPW; k++) begin
      if (sym_valid && cnt_q == CNT_W'(k)) begin
        if (LSB_FIRST != 0)
          push_word[2*k +: 2] = sym_in;
        else
          push_word[WORD_W-2-2*k +: 2] = sym_in;
      end
    end
    last_sym     = sym_valid && (cnt_q == LAST_CNT);
    push         = last_sym || (flush && (state_q == ST_FILLING || sym_valid));
    push_partial = !last_sym;
  end

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (push) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (sym_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
      sr_d  = push_word;
    end
  end

  // ---------------- FIFO ----------------
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  part_q, part_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic              head_part_q, head_part_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              pop, do_write, ovf_set;
  logic              head_from_push;

`ifdef PACK_PARITY_EN
  logic [DEPTH-1:0]  par_q, par_d;
  logic              head_par_q, head_par_d;
  logic              push_par;
`endif

  always_comb begin
    pop      = valid_q && word_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot being written.
    do_write = push && ((level_q != FULL_LVL) || pop);
    ovf_set  = push && (level_q == FULL_LVL) && !pop;

    wr_ptr_d = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case ({do_write, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    mem_d  = mem_q;
    part_d = part_q;
    if (do_write) begin
      mem_d[wr_ptr_q]  = push_word;
      part_d[wr_ptr_q] = push_partial;
    end

    // The new head is the word being written only when the FIFO is empty
    // after this cycle's pop; otherwise it is already in storage.
    head_from_push = do_write && (wr_ptr_q == rd_ptr_d);
    head_d      = head_q;
    head_part_d = head_part_q;
    if (level_d != '0) begin
      head_d      = head_from_push ? push_word    : mem_q[rd_ptr_d];
      head_part_d = head_from_push ? push_partial : part_q[rd_ptr_d];
    end
    valid_d = (level_d != '0);

    overflow_d = overflow_q;
    if (ovf_set)
      overflow_d = 1'b1;
    else if (overflow_clr)
      overflow_d = 1'b0;
  end

`ifdef PACK_PARITY_EN
  always_comb begin
    push_par = ^push_word;
    par_d    = par_q;
    if (do_write)
      par_d[wr_ptr_q] = push_par;
    head_par_d = head_par_q;
    if (level_d != '0)
      head_par_d = head_from_push ? push_par : par_q[rd_ptr_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q      <= '0;
      head_par_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      head_par_q <= head_par_d;
    end
  end

  assign word_parity = head_par_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      part_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= '0;
      head_part_q <= 1'b0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
      part_q      <= part_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      head_q      <= head_d;
      head_part_q <= head_part_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign word_out     = head_q;
  assign word_partial = head_part_q;
  assign word_valid   = valid_q;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_mealy_sym_packer.sv
// Directed bench for mealy_sym_packer. Two instances share the same stimulus:
// dut packs LSB first and dut_m packs MSB first.

module tb_mealy_sym_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       flush;
  logic       word_ready;
  logic       overflow_clr;

  logic [7:0] word_out,   word_out_m;
  logic       word_partial, word_partial_m;
  logic       word_valid, word_valid_m;
  logic [2:0] fifo_level, fifo_level_m;
  logic       overflow,   overflow_m;
`ifdef PACK_PARITY_EN
  logic       word_parity, word_parity_m;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mealy_sym_packer #(.WORD_W(8), .DEPTH(4), .LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .flush(flush), .word_out(word_out), .word_partial(word_partial),
`ifdef PACK_PARITY_EN
    .word_parity(word_parity),
`endif
    .word_valid(word_valid), .word_ready(word_ready),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  mealy_sym_packer #(.WORD_W(8), .DEPTH(4), .LSB_FIRST(0)) dut_m (
    .clk(clk), .reset(reset), .sym_in(sym_in), .sym_valid(sym_valid),
    .flush(flush), .word_out(word_out_m), .word_partial(word_partial_m),
`ifdef PACK_PARITY_EN
    .word_parity(word_parity_m),
`endif
    .word_valid(word_valid_m), .word_ready(word_ready),
    .fifo_level(fifo_level_m), .overflow(overflow_m), .overflow_clr(overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic fl);
    sym_in    = s;
    sym_valid = 1'b1;
    flush     = fl;
    tick();
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Pushes one full word LSB-first; word_ready is held during the last symbol.
  task automatic push_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) word_ready = rdy_last;
      send(w[2*i +: 2], 1'b0);
    end
    word_ready = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    reset = 1'b1; sym_in = '0; sym_valid = 1'b0; flush = 1'b0;
    word_ready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", word_valid, 0);
    chk("rst_word",  word_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf",   overflow, 0);
    reset = 1'b0;
    tick();

    // Fill: 01,10,11,00 -> 0x39 (LSB first), 0x6C (MSB first)
    word_ready = 1'b1;
    sym_valid  = 1'b1;
    sym_in = 2'b01; tick();
    sym_in = 2'b10; tick();
    sym_in = 2'b11; tick();
    chk("fill_not_yet", word_valid, 0);
    sym_in = 2'b00; tick();
    sym_valid = 1'b0;
    chk("fill_valid",   word_valid, 1);
    chk("fill_lsb",     word_out, 8'h39);
    chk("fill_partial", word_partial, 0);
    chk("fill_msb",     word_out_m, 8'h6C);
`ifdef PACK_PARITY_EN
    chk("fill_par",     word_parity, 0);
`endif
    tick();
    chk("pop_empty", word_valid, 0);
    chk("pop_level", fifo_level, 0);
    chk("pop_hold",  word_out, 8'h39);

    // Flush after two symbols: 11,01 -> 0x07 partial; MSB first -> 0xD0
    word_ready = 1'b0;
    send(2'b11, 1'b0);
    send(2'b01, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_level",   fifo_level, 1);
    chk("flush_word",    word_out, 8'h07);
    chk("flush_partial", word_partial, 1);
    chk("flush_msb",     word_out_m, 8'hD0);
`ifdef PACK_PARITY_EN
    chk("flush_par",     word_parity, 1);
`endif
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_noop", fifo_level, 1);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    chk("flush_drain", fifo_level, 0);

    // Flush with the completing symbol -> one full push; flush with extending symbol -> partial
    send(2'b00, 1'b0); send(2'b00, 1'b0); send(2'b00, 1'b0);
    send(2'b11, 1'b1);
    chk("flfull_level",   fifo_level, 1);
    chk("flfull_word",    word_out, 8'hC0);
    chk("flfull_partial", word_partial, 0);
    send(2'b10, 1'b0);
    send(2'b01, 1'b1);
    chk("flext_level", fifo_level, 2);
    chk("flext_head",  word_out, 8'hC0);
    word_ready = 1'b1; tick();
    chk("flext_word",    word_out, 8'h06);
    chk("flext_partial", word_partial, 1);
    tick(); word_ready = 1'b0;
    chk("flext_drain", fifo_level, 0);

    // Overflow: five words into a four-deep FIFO
    exp_q = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    foreach (exp_q[i]) push_word(exp_q[i], 1'b0);
    chk("ovf_full_lvl", fifo_level, 4);
    chk("ovf_not_yet",  overflow, 0);
    push_word(8'h39, 1'b0);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_set",   overflow, 1);
    word_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk($sformatf("ovf_drain%0d", i), word_out, exp_q[i]);
      tick();
    end
    word_ready = 1'b0;
    chk("ovf_empty",  word_valid, 0);
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO with simultaneous push and pop
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (exp_q[i]) push_word(exp_q[i], 1'b0);
    push_word(8'h55, 1'b1);
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf",   overflow, 0);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    word_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk($sformatf("pp_drain%0d", i), word_out, exp_q[i]);
      tick();
    end
    word_ready = 1'b0;
    chk("pp_empty", fifo_level, 0);

    // Reset mid-word with two words stored
    push_word(8'h12, 1'b0);
    push_word(8'h34, 1'b0);
    send(2'b01, 1'b0); send(2'b10, 1'b0); send(2'b11, 1'b0);
    chk("prerst_level", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_valid", word_valid, 0);
    chk("arst_word",  word_out, 0);
    tick();
    reset = 1'b0;
    send(2'b11, 1'b0); send(2'b11, 1'b0); send(2'b00, 1'b0); send(2'b01, 1'b0);
    chk("post_level",   fifo_level, 1);
    chk("post_word",    word_out, 8'h4F);
    chk("post_partial", word_partial, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mealy_sym_packer.md
Name: mealy_sym_packer

Overview:
- Downstream consumer of the 4-state Mealy detector's 2-bit symbol stream.
- Samples one 2-bit symbol per clock when sym_valid is high and packs consecutive symbols into WORD_W-bit words.
- Buffers completed words in a small first-word-fall-through FIFO with a valid/ready output port feeding the bus-side logic.

Parameters:
- WORD_W, 8: packed word width; even, >= 4; symbols per word SPW = WORD_W/2.
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- LSB_FIRST, 1: 1 = first symbol goes to bits [1:0]; 0 = first symbol goes to bits [WORD_W-1:WORD_W-2].

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sym_in  input  2  symbol from the Mealy stage (combinational there; sampled here at clk edge).
- sym_valid  input  1  sym_in is accepted on this edge.
- flush  input  1  close the partial word (zero-padded) and push it.
- word_out  output  WORD_W  FIFO head word.
- word_partial  output  1  head word was closed by flush, not by filling.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer takes the head word when word_valid && word_ready.
- fifo_level  output  $clog2(DEPTH+1)  number of stored words.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async): symbol count = 0, shift register = 0, FIFO empty. Outputs: word_out = 0, word_partial = 0, word_valid = 0, fifo_level = 0, overflow = 0.
- Packer states: EMPTY (count = 0) and FILLING (0 < count < SPW).
- Accepted symbol k (0..SPW-1) is written to slot k.
  - LSB_FIRST = 1: bits [2k+1:2k].
  - LSB_FIRST = 0: bits [WORD_W-1-2k : WORD_W-2-2k].
- Full-word push: on the edge accepting symbol SPW-1, the completed word (including that symbol) is pushed with partial = 0. Count returns to 0 and the state returns to EMPTY on the same edge.
  - Latency: word_valid and word_out are valid the cycle after the last symbol edge.
- Flush:
  - flush with count > 0: push the accumulated word, unfilled slots = 0, partial = 1. Return to EMPTY.
  - flush with count = 0 and no symbol that cycle: no-op, no push.
  - flush together with sym_valid: the symbol is included first.
    - If the symbol completes the word, exactly one push with partial = 0.
    - Otherwise, one push of the extended partial word with partial = 1.
  - At most one push per cycle.
- Pop: word_valid && word_ready advances the FIFO head on that edge. word_out and word_partial show the new head, or hold the last value when the FIFO goes empty.
- Simultaneous push and pop: always allowed, including when full. fifo_level is unchanged.
- Push when full without a pop: the word is dropped and overflow is set to 1. FIFO contents and level are unchanged. Packer state still resets to EMPTY.
- overflow priority: a set in the same cycle wins over overflow_clr.
- fifo_level range is 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- No combinational path from any input to any output; all outputs are registered or driven directly from registers.
- Reset mid-word or with a non-empty FIFO discards everything immediately.

Optional Feature:
- Macro: PACK_PARITY_EN.
- Defined:
  - Adds output word_parity (1 bit) = even parity (XOR) of the head word_out.
  - Parity is computed at push time and stored in the FIFO entry.
  - Reset value is 0.
- Undefined: no port, no storage, no logic.

Test Plan:
- Fill, LSB first: WORD_W=8, LSB_FIRST=1, word_ready=1; symbols 01,10,11,00 on consecutive cycles -> word_valid one cycle after the 4th symbol, word_out=0x39, word_partial=0, parity 0 (if enabled).
- Fill, MSB first: LSB_FIRST=0, same symbols -> word_out=0x6C.
- Flush after 2 symbols: symbols 11,01 then flush (LSB_FIRST=1) -> word_out=0x07, word_partial=1.
  - Flush with no symbols stored -> no push.
- Overflow: word_ready=0, DEPTH=4, push 5 full words 0x00,0x55,0xAA,0xFF,0x39 -> fifo_level=4, overflow=1. Draining returns 0x00,0x55,0xAA,0xFF; 0x39 is never output. overflow_clr -> overflow=0.
- Full FIFO push and pop: FIFO full, word_ready=1 on the same edge a 5th word completes -> no overflow, fifo_level stays 4, order preserved.
- Reset: assert reset after 3 symbols with 2 words stored -> all outputs 0 immediately. Then 4 new symbols produce one correct word with no leftover slots.
